// File: rtl/vec_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vec_pkg                                                       |
// | Purpose  : Shared types and constants for the Filter-GPU vector decode   |
// |            stage: default lane count/width, the default vector type,     |
// |            instruction field positions and the PC alias register index.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package vec_pkg;

  // Default geometry used when a module is instantiated without overrides
  localparam int DEF_LANES  = 3;
  localparam int DEF_DATA_W = 18;

  typedef logic [DEF_LANES-1:0][DEF_DATA_W-1:0] vec_t;

  // Instruction field positions
  localparam int RN_HI = 19;
  localparam int RN_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 12;
  localparam int RM_HI = 3;
  localparam int RM_LO = 0;

  // Immediate field tops (both fields start at bit 0)
  localparam int IMM12_HI = 11;
  localparam int IMM8_HI  = 7;

  // Register index that aliases to PC+8 on reads and ignores writes
  localparam int PC_REG = 15;

endpackage : vec_pkg
`default_nettype wire

// File: rtl/vec_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vec_regfile                                                   |
// | Purpose  : NREGS x (LANES x DATA_W) vector register file, 2 combinational|
// |            read ports, 1 synchronous write port, r15 read alias to PC+8, |
// |            synchronous clear on reset.                                   |
// | Macro    : DECODE_BYPASS_EN - when defined, a same-cycle write to a read |
// |            address is forwarded to that read port.                       |
// | Ports    : clk, rst                  clock / sync active-high reset      |
// |            i_ra1, i_ra2 / o_rd1,o_rd2  read addresses / read vectors     |
// |            i_pc8                     PC+8, returned for reads of r15     |
// |            i_we, i_wa, i_wd          write enable / address / vector     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module vec_regfile
  import vec_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = 16,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AW-1:0]                 i_ra1,
  input  logic [AW-1:0]                 i_ra2,
  output logic [LANES-1:0][DATA_W-1:0]  o_rd1,
  output logic [LANES-1:0][DATA_W-1:0]  o_rd2,
  input  logic [DATA_W-1:0]             i_pc8,
  input  logic                          i_we,
  input  logic [AW-1:0]                 i_wa,
  input  logic [LANES-1:0][DATA_W-1:0]  i_wd
);

  localparam logic [AW-1:0] PC_ADDR = AW'(PC_REG);

  logic [LANES-1:0][DATA_W-1:0] r_regs [NREGS];
  logic                         w_wr_en;

  // Writes to the PC alias are silently dropped
  assign w_wr_en = i_we && (i_wa != PC_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  // The PC alias takes precedence; a forwarded write can never target r15
  // because w_wr_en already excludes it.
  always_comb begin
    o_rd1 = r_regs[i_ra1];
    if (i_ra1 == PC_ADDR) begin
      o_rd1 = {LANES{i_pc8}};
    end
`ifdef DECODE_BYPASS_EN
    else if (w_wr_en && (i_wa == i_ra1)) begin
      o_rd1 = i_wd;
    end
`endif
  end

  always_comb begin
    o_rd2 = r_regs[i_ra2];
    if (i_ra2 == PC_ADDR) begin
      o_rd2 = {LANES{i_pc8}};
    end
`ifdef DECODE_BYPASS_EN
    else if (w_wr_en && (i_wa == i_ra2)) begin
      o_rd2 = i_wd;
    end
`endif
  end

endmodule : vec_regfile
`default_nettype wire

// File: rtl/vec_decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vec_decode_stage                                              |
// | Purpose  : Vector pipeline decode stage. Extracts Rn/Rd/Rm and immediate |
// |            fields, reads two operand vectors, applies optional scalar    |
// |            broadcast on operand 2 and registers everything into the D->E |
// |            pipeline register (priority rst > flush > stall > load).      |
// | Macro    : DECODE_BYPASS_EN - same-cycle writeback-to-read forwarding in |
// |            the register file.                                            |
// | Ports    : clk, rst                 clock / sync active-high reset       |
// |            stall_d, flush_d         hold / bubble the D->E register      |
// |            valid_d, instr_d         decode-stage instruction             |
// |            imm_src_d                0: imm8, 1: imm12                    |
// |            reg_src_d                [0] ra1=r15 [1] ra2=Rd [2] broadcast |
// |            pc8_d                    PC+8 returned for r15 reads          |
// |            reg_write_w,wa3_w,wd3_w  writeback port                       |
// |            valid_e, rd1_e, rd2_e, ext_imm_e, wa3_e   E-stage outputs     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module vec_decode_stage
  import vec_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = 16,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall_d,
  input  logic                          flush_d,
  input  logic                          valid_d,
  input  logic [31:0]                   instr_d,
  input  logic                          imm_src_d,
  input  logic [2:0]                    reg_src_d,
  input  logic [DATA_W-1:0]             pc8_d,
  input  logic                          reg_write_w,
  input  logic [AW-1:0]                 wa3_w,
  input  logic [LANES-1:0][DATA_W-1:0]  wd3_w,
  output logic                          valid_e,
  output logic [LANES-1:0][DATA_W-1:0]  rd1_e,
  output logic [LANES-1:0][DATA_W-1:0]  rd2_e,
  output logic [LANES-1:0][DATA_W-1:0]  ext_imm_e,
  output logic [AW-1:0]                 wa3_e
);

  localparam logic [AW-1:0] PC_ADDR = AW'(PC_REG);

  logic [AW-1:0]                w_ra1;
  logic [AW-1:0]                w_ra2;
  logic [AW-1:0]                w_wa3;
  logic [LANES-1:0][DATA_W-1:0] w_rd1;
  logic [LANES-1:0][DATA_W-1:0] w_rd2;
  logic [LANES-1:0][DATA_W-1:0] w_rd2_bc;
  logic [IMM12_HI:0]            w_imm12;
  logic [DATA_W-1:0]            w_imm;
  logic                         w_unused_instr;

  // Opcode/condition bits are decoded elsewhere in the pipeline
  assign w_unused_instr = &{1'b0, instr_d[31:RN_HI+1]};

  assign w_ra1 = reg_src_d[0] ? PC_ADDR : AW'(instr_d[RN_HI:RN_LO]);
  assign w_ra2 = reg_src_d[1] ? AW'(instr_d[RD_HI:RD_LO])
                              : AW'(instr_d[RM_HI:RM_LO]);
  assign w_wa3 = AW'(instr_d[RD_HI:RD_LO]);

  vec_regfile #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .AW     (AW)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .i_ra1 (w_ra1),
    .i_ra2 (w_ra2),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2),
    .i_pc8 (pc8_d),
    .i_we  (reg_write_w),
    .i_wa  (wa3_w),
    .i_wd  (wd3_w)
  );

  // Broadcast sits after the register file so a forwarded lane 0 is spread
  always_comb begin
    w_rd2_bc = w_rd2;
    if (reg_src_d[2]) begin
      for (int i = 0; i < LANES; i++) begin
        w_rd2_bc[i] = w_rd2[0];
      end
    end
  end

  // Size cast zero-extends for wide lanes and keeps the low bits for narrow ones
  assign w_imm12 = imm_src_d ? instr_d[IMM12_HI:0]
                             : {{(IMM12_HI-IMM8_HI){1'b0}}, instr_d[IMM8_HI:0]};
  assign w_imm   = DATA_W'(w_imm12);

  always_ff @(posedge clk) begin
    if (rst || flush_d) begin
      valid_e   <= 1'b0;
      rd1_e     <= '0;
      rd2_e     <= '0;
      ext_imm_e <= '0;
      wa3_e     <= '0;
    end else if (!stall_d) begin
      valid_e   <= valid_d;
      rd1_e     <= w_rd1;
      rd2_e     <= w_rd2_bc;
      ext_imm_e <= {LANES{w_imm}};
      wa3_e     <= w_wa3;
    end
  end

endmodule : vec_decode_stage
`default_nettype wire
